// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg: GF(2^8) constants, multipliers and the Chien FSM state type shared by the RS decoder.
// Field is GF(2^8) with primitive polynomial 0x11D and alpha = 0x02.
package rs_gf_pkg;
  localparam int GF_W = 8;
  localparam logic [GF_W:0] GF_POLY = 9'h11D;
  localparam logic [GF_W-1:0] GF_ALPHA = 8'h02;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} chien_state_e;
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
    logic [GF_W-1:0] p;
    p = '0;
    for (int i = GF_W - 1; i >= 0; i--) begin
      p = {p[GF_W-2:0], 1'b0} ^ (p[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
      p = p ^ (b[i] ? a : '0);
    end
    return p;
  endfunction
  function automatic logic [GF_W-1:0] gf_alpha_pow(input int e);
    logic [GF_W-1:0] p;
    p = 8'h01;
    for (int i = 0; i < e; i++) p = gf_mul(p, GF_ALPHA);
    return p;
  endfunction
  // c is an elaboration-time constant, so this folds to an XOR network
  function automatic logic [GF_W-1:0] gf_mul_const(input logic [GF_W-1:0] a, input logic [GF_W-1:0] c);
    return gf_mul(a, c);
  endfunction
endpackage

// File: rtl/chien_cell.sv
// chien_cell: one locator term register r_k with load mux and constant multiplier by alpha^-k.
// Ports: clk, rst_n (async active-low), load (take sigma), step (r <= r*alpha^-k), sigma (sigma_k), r (current term).
module chien_cell
  import rs_gf_pkg::*;
#(
  parameter int K = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [GF_W-1:0] sigma,
  output logic [GF_W-1:0] r
);
  localparam logic [GF_W-1:0] ALPHA_INV_K = gf_alpha_pow(255 - K);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else if (load) r <= sigma;
    else if (step) r <= gf_mul_const(r, ALPHA_INV_K);
endmodule

// File: rtl/chien_search_param.sv
// chien_search_param: Chien search over GF(2^8), one codeword position per clock, start/done framed.
// Ports: clk, rst_n (async active-low), start, sigma[8*T] (sigma_k at [8k-1:8k-8]),
//   busy, done (1-cycle pulse), location[8*T] (root positions, ascending), loc_valid[T],
//   err_count (saturates at T), fail (count != deg Lambda or more than T roots).
// Optional CHIEN_FORNEY_DERIV_EN adds loc_deriv[8*T]: odd-term sum at each root (alpha^-i * Lambda'(alpha^-i)).
module chien_search_param
  import rs_gf_pkg::*;
#(
  parameter int T = 8,
  parameter int N = 204
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [8*T-1:0] sigma,
  output logic           busy,
  output logic           done,
  output logic [8*T-1:0] location,
  output logic [T-1:0]   loc_valid,
  output logic [4:0]     err_count,
  output logic           fail
`ifdef CHIEN_FORNEY_DERIV_EN
  ,
  output logic [8*T-1:0] loc_deriv
`endif
);
  chien_state_e state, state_nx;
  logic [GF_W-1:0] r [T];
  logic [GF_W-1:0] idx, sum;
  logic [4:0] deg, deg_in;
  logic fail_q, load, step, root, full;
  assign load = state == IDLE && start;
  assign step = state == SEARCH;
  assign root = step && sum == '0;
  assign full = err_count == 5'(T);
  for (genvar k = 0; k < T; k++) begin : g_cell
    chien_cell #(.K(k + 1)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .step (step),
      .sigma(sigma[8*k +: 8]),
      .r    (r[k])
    );
  end
  // sum is Lambda(alpha^-idx) with the implicit sigma0 = 1
  always_comb begin
    sum = 8'h01;
    deg_in = '0;
    for (int k = 0; k < T; k++) begin
      sum = sum ^ r[k];
      if (sigma[8*k +: 8] != '0) deg_in = 5'(k + 1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? SEARCH : IDLE) :
               state == SEARCH ? (idx == 8'(N - 1) ? DONE : SEARCH) : IDLE;
  // the degree check is folded into fail combinationally so it is valid during the done pulse
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    fail = fail_q | (done && err_count != deg);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      deg <= '0;
      location <= '0;
      loc_valid <= '0;
      err_count <= '0;
      fail_q <= 1'b0;
    end else if (load) begin
      idx <= '0;
      deg <= deg_in;
      location <= '0;
      loc_valid <= '0;
      err_count <= '0;
      fail_q <= 1'b0;
    end else if (step) begin
      idx <= idx + 8'd1;
      if (root && full) fail_q <= 1'b1;
      else if (root) begin
        for (int s = 0; s < T; s++)
          if (5'(s) == err_count) begin
            location[8*s +: 8] <= idx;
            loc_valid[s] <= 1'b1;
          end
        err_count <= err_count + 5'd1;
      end
    end else if (done) fail_q <= fail;
`ifdef CHIEN_FORNEY_DERIV_EN
  logic [GF_W-1:0] odd;
  // r[k] holds the term for sigma_(k+1), so even k are the odd powers
  always_comb begin
    odd = '0;
    for (int k = 0; k < T; k += 2) odd = odd ^ r[k];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) loc_deriv <= '0;
    else if (load) loc_deriv <= '0;
    else if (root && !full)
      for (int s = 0; s < T; s++)
        if (5'(s) == err_count) loc_deriv[8*s +: 8] <= odd;
`endif
endmodule

// File: tb/tb_chien_search_param.sv
// tb_chien_search_param: scoreboard bench for chien_search_param using a table-based GF reference model.
module tb_chien_search_param;
  localparam int T = 8;
  localparam int N = 204;
  typedef struct packed {
    logic [8*T-1:0] loc;
    logic [8*T-1:0] deriv;
    logic [T-1:0]   valid;
    logic [4:0]     cnt;
    logic           fail;
  } res_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [8*T-1:0] sigma = '0;
  logic busy, done, fail;
  logic [8*T-1:0] location;
  logic [T-1:0] loc_valid;
  logic [4:0] err_count;
`ifdef CHIEN_FORNEY_DERIV_EN
  logic [8*T-1:0] loc_deriv;
`endif
  res_t sb[$];
  int n_tests = 0, n_fail = 0;
  int gexp[256], glog[256];
  chien_search_param #(.T(T), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sigma    (sigma),
    .busy     (busy),
    .done     (done),
    .location (location),
    .loc_valid(loc_valid),
    .err_count(err_count),
    .fail     (fail)
`ifdef CHIEN_FORNEY_DERIV_EN
    ,
    .loc_deriv(loc_deriv)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int gmul(input int a, input int b);
    return (a == 0 || b == 0) ? 0 : gexp[(glog[a] + glog[b]) % 255];
  endfunction
  function automatic res_t model(input logic [8*T-1:0] s);
    res_t e;
    int d, x, xp, acc, od, t;
    e = '0;
    d = 0;
    for (int k = 1; k <= T; k++) if (s[8*k-1 -: 8] != 0) d = k;
    for (int i = 0; i < N; i++) begin
      x = gexp[(255 - i) % 255];
      xp = 1;
      acc = 1;
      od = 0;
      for (int k = 1; k <= T; k++) begin
        xp = gmul(xp, x);
        t = gmul(int'(s[8*k-1 -: 8]), xp);
        acc ^= t;
        if (k % 2 == 1) od ^= t;
      end
      if (acc == 0) begin
        if (int'(e.cnt) < T) begin
          e.loc[8*e.cnt +: 8] = 8'(i);
          e.deriv[8*e.cnt +: 8] = 8'(od);
          e.valid[e.cnt] = 1'b1;
          e.cnt = e.cnt + 5'd1;
        end else e.fail = 1'b1;
      end
    end
    if (int'(e.cnt) != d) e.fail = 1'b1;
    return e;
  endfunction
  // Lambda = prod (1 + alpha^p x) over n distinct random positions p
  function automatic logic [8*T-1:0] from_roots(input int n);
    int c[T+1];
    int p[$];
    int v;
    logic [8*T-1:0] s;
    while (p.size() < n) begin
      v = int'($urandom_range(N - 1, 0));
      if (!(v inside {p})) p.push_back(v);
    end
    c[0] = 1;
    for (int k = 1; k <= T; k++) c[k] = 0;
    foreach (p[j])
      for (int k = T; k >= 1; k--) c[k] ^= gmul(gexp[p[j]], c[k-1]);
    s = '0;
    for (int k = 1; k <= T; k++) s[8*k-1 -: 8] = 8'(c[k]);
    return s;
  endfunction
  task automatic run(input logic [8*T-1:0] s, input int inj = 0, input logic [8*T-1:0] s2 = '0);
    res_t e;
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    sigma = s;
    sb.push_back(model(s));
    for (int k = 1; k <= N + 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_on", busy, 1);
      if (done) lat = k;
      start = k == inj;
      if (k == inj) sigma = s2;
    end
    check("latency", lat, N + 1);
    e = sb.pop_front();
    check("busy_done", busy, 1);
    check("location", location, e.loc);
    check("loc_valid", loc_valid, e.valid);
    check("err_count", err_count, e.cnt);
    check("fail", fail, e.fail);
`ifdef CHIEN_FORNEY_DERIV_EN
    check("loc_deriv", loc_deriv, e.deriv);
`endif
    @(negedge clk);
    check("busy_off", busy, 0);
    check("done_off", done, 0);
    check("hold_loc", location, e.loc);
    check("hold_cnt", err_count, e.cnt);
    check("hold_fail", fail, e.fail);
  endtask
  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v << 1;
      if ((v & 256) != 0) v ^= 'h11D;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_loc", location, 0);
    check("rst_valid", loc_valid, 0);
    check("rst_cnt", err_count, 0);
    check("rst_fail", fail, 0);
    rst_n = 1'b1;
    run(64'h20);
    run(64'h0203);
    run(64'h0100);
    run(64'h0);
    run(64'h0203, 50, 64'h20);
    run(from_roots(3));
    run(from_roots(T));
    run({$urandom, $urandom});
    run({$urandom, $urandom});
    @(negedge clk);
    start = 1'b1;
    sigma = from_roots(4);
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_loc", location, 0);
    check("abort_valid", loc_valid, 0);
    check("abort_cnt", err_count, 0);
    check("abort_fail", fail, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(from_roots(5));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
